// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU
//
// This block takes one request at a time. The request is captured on the edge
// where the FSM is idle and start is high.
//   * ADD, SUB, AND, OR, XOR, SHL and the reserved code finish on the
//     accepting edge. The FSM goes straight to DONE.
//   * MUL runs an unsigned shift-add over WIDTH iterations. It then spends
//     one more edge copying the product to result and entering DONE.
// result and err are registered. They hold their value until the next
// completion. The MUL accumulator is internal, so partial products are never
// visible on result.
//
// Ports
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous, active-high reset
//   start   in   1          request, sampled only while busy=0
//   op      in   3          000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                           101 MUL, 110 SHL, 111 reserved
//   a       in   WIDTH      operand A (unsigned)
//   b       in   WIDTH      operand B (unsigned)
//   busy    out  1          high whenever the FSM is not IDLE
//   done    out  1          one-cycle completion pulse (state DONE)
//   result  out  2*WIDTH    registered result
//   err     out  1          high when the last completed op was reserved
// ----------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);

    localparam int RW = 2 * WIDTH;
    // Shift amount field width: b[clog2(WIDTH)-1:0].
    localparam int SW = $clog2(WIDTH);
    // The iteration counter must be able to hold WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    // Shift-add multiplier datapath.
    logic [RW-1:0]    mcand;    // multiplicand, shifted left each iteration
    logic [WIDTH-1:0] mplier;   // multiplier, shifted right each iteration
    logic [RW-1:0]    acc;      // running partial product
    logic [CW-1:0]    cnt;      // iterations completed so far

    // Single-cycle ALU result, computed from the live inputs.
    // It is only written to result on the accepting edge.
    logic [RW-1:0]    alu_res;
    logic             alu_err;

    logic             mul_last;

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    // cnt reaching WIDTH means all iterations are finished. That edge
    // publishes the product.
    assign mul_last = (cnt == CW'(WIDTH));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case. This means no path
    // leaves it unassigned, so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (op == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    next_state = DONE;
                end
            end
            // DONE always returns to IDLE. start is not looked at here, so a
            // request held high is taken on the next IDLE edge, not queued.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: alu_res[WIDTH:0]   = {1'b0, a} + {1'b0, b};
            // A (WIDTH+1)-bit difference wraps mod 2^(WIDTH+1). Bit WIDTH then
            // acts as the borrow, set exactly when a < b.
            OP_SUB: alu_res[WIDTH:0]   = {1'b0, a} - {1'b0, b};
            OP_AND: alu_res[WIDTH-1:0] = a & b;
            OP_OR:  alu_res[WIDTH-1:0] = a | b;
            OP_XOR: alu_res[WIDTH-1:0] = a ^ b;
            OP_SHL: alu_res            = {{WIDTH{1'b0}}, a} << b[SW-1:0];
            OP_RSV: alu_err            = 1'b1;
            default: ;  // MUL goes through the iterative datapath
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: every datapath register is reset here, the multiplier state as well
    // as result/err. A MUL aborted by reset therefore leaves nothing behind,
    // and result reads 0 as soon as rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            err    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            // Operands are copied here. Later changes on a/b
                            // cannot disturb the running multiply.
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            err    <= alu_err;
                        end
                    end
                end
                MUL: begin
                    if (!mul_last) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end else begin
                        result <= acc;
                        err    <= 1'b0;
                    end
                end
                default: ;  // DONE: outputs hold
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ----------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (WIDTH=8)
//
// Stimulus tasks drive requests on the falling edge. Each request pushes its
// expected result, expected err and expected time of the done sample into a
// scoreboard queue. A separate monitor samples on the falling edge. Whenever
// done is high it pops one entry and compares it. A done with nothing
// outstanding is an error. This also catches pulses that last too long and
// starts that should have been ignored.
// ----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 8;
    localparam time PERIOD = 10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        time            t;    // expected time of the falling edge showing done
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           err;

    exp_t           sb[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] last_res;
    logic           last_err;

    alu_mc #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no outstanding request at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("err", err, mon_e.err);
                check("done_time", $time, mon_e.t);
                check("busy_with_done", busy, 1);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy=1 required=0 after 50 cycles");
        end
    endtask

    // Issues one request and tracks it to completion. The accepting edge
    // enters DONE for single-cycle ops, and DONE is entered W+1 edges later
    // for MUL. The done sample is therefore half a period after that.
    // While waiting, a, b and op are disturbed so the latched copies are exercised.
    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] er, input logic ee);
        time e0;
        int  k;
        bit  seen;
        k = (o == OP_MUL) ? (W + 1) : 0;
        wait_idle();
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        e0 = $time;
        sb.push_back('{res: er, err: ee, t: e0 + time'(k) * PERIOD + PERIOD/2});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                op    = ~o;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_during_op", busy, 1);
                check("result_hold", result, last_res);
                check("err_hold", err, last_err);
            end
            a = ~a;
            b = b + 8'd37;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: op=%0d no done within 40 cycles", o);
        end
        #1;
        check("scoreboard_drained", sb.size(), 0);
        last_res = er;
        last_err = ee;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time t0;
        int  n;
        rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
        last_res = '0;
        last_err = 1'b0;

        // Reset state, observed after a clock edge while rst is held.
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        run(OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0);
        run(OP_SUB, 8'd3,   8'd5,   16'h01FE, 1'b0);
        run(OP_SUB, 8'd5,   8'd3,   16'h0002, 1'b0);
        run(OP_AND, 8'hF0,  8'h3C,  16'h0030, 1'b0);
        run(OP_OR,  8'hF0,  8'h3C,  16'h00FC, 1'b0);
        run(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0);
        run(OP_SHL, 8'h81,  8'h0B,  16'h0408, 1'b0);
        run(OP_RSV, 8'h12,  8'h34,  16'h0000, 1'b1);
        run(OP_XOR, 8'hF0,  8'h3C,  16'h00CC, 1'b0);
        run(OP_ADD, 8'd255, 8'd255, 16'h01FE, 1'b0);
        run(OP_SHL, 8'hFF,  8'h07,  16'h7F80, 1'b0);
        run(OP_MUL, 8'd13,  8'd11,  16'h008F, 1'b0);
        run(OP_MUL, 8'd0,   8'd200, 16'h0000, 1'b0);
        run(OP_MUL, 8'd200, 8'd3,   16'h0258, 1'b0);

        // Reset in the middle of a MUL: this request has no scoreboard entry,
        // so any done pulse from it would be reported.
        wait_idle();
        start = 1'b1; op = OP_MUL; a = 8'd9; b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_err", err, 0);
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_held", busy, 0);
        rst = 1'b0;
        last_res = '0;
        last_err = 1'b0;
        run(OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0);

        // start held high: accepted every second edge, with DONE in between.
        wait_idle();
        start = 1'b1; op = OP_ADD; a = 8'd7; b = 8'd9;
        @(posedge clk);
        t0 = $time;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{res: 16'h0010, err: 1'b0, t: t0 + time'(2 * k) * PERIOD + PERIOD/2});
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("b2b_drained", sb.size(), 0);
        last_res = 16'h0010;
        last_err = 1'b0;

        repeat (5) @(negedge clk);
        check("final_drained", sb.size(), 0);
        check("final_idle", busy, 0);
        check("final_result_hold", result, last_res);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal values 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only when busy=0.
REQ-005 Port: op  input  3  operation code, sampled with start.
REQ-006 Port: a  input  WIDTH  operand A, unsigned, sampled with start.
REQ-007 Port: b  input  WIDTH  operand B, unsigned, sampled with start.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: result  output  2*WIDTH  registered result.
REQ-011 Port: err  output  1  registered flag, high when the last accepted op was reserved.

Function
REQ-012 The block SHALL decode op as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 reserved.
REQ-013 The block SHALL use FSM states IDLE, MUL, DONE; IDLE->DONE on start with non-MUL op; IDLE->MUL on start with op=101; MUL->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-014 The accepting edge E0 SHALL be the rising edge where state=IDLE and start=1; a, b and op SHALL be latched at E0 and later input changes SHALL have no effect.
REQ-015 ADD SHALL give result[WIDTH:0] = a+b, with bit WIDTH as carry-out and all upper bits 0.
REQ-016 SUB SHALL give result[WIDTH:0] = (a-b) mod 2^(WIDTH+1), so bit WIDTH=1 iff a<b, with upper bits 0.
REQ-017 AND, OR and XOR SHALL be bitwise on result[WIDTH-1:0] with upper bits 0.
REQ-018 SHL SHALL give result = zero-extended a shifted left by b[clog2(WIDTH)-1:0] within 2*WIDTH bits.
REQ-019 MUL SHALL be an unsigned shift-add over exactly WIDTH iterations (edges E1..E_WIDTH), giving the full 2*WIDTH-bit product, and SHALL enter DONE at edge E_WIDTH+1.
REQ-020 Reserved op SHALL give result=0 and err=1; every other op SHALL clear err at completion.
REQ-021 Non-MUL ops SHALL write result at E0 and enter DONE at E0, so done is high in the cycle after E0 (latency 1).
REQ-022 MUL latency SHALL be WIDTH+1 cycles from E0 to done high.
REQ-023 done SHALL be high for exactly one cycle, only while state=DONE.
REQ-024 start SHALL be ignored while busy=1, including in state DONE, with no queuing.
REQ-025 result and err SHALL hold their values from completion until the next completion; intermediate MUL values SHALL NOT appear on result.
REQ-026 Back-to-back: start held high SHALL be accepted again on the first edge in IDLE after DONE.

Reset
REQ-027 While rst=1: state=IDLE, busy=0, done=0, err=0, result=0, and the iteration counter and MUL accumulator are cleared, independent of clk.
REQ-028 Reset asserted mid-MUL SHALL abort the operation with no done pulse, and result SHALL read 0.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-030 ADD a=200, b=100 -> result=0x012C, done one cycle after E0, err=0.
REQ-031 SUB a=3, b=5 -> result=0x01FE; SUB a=5, b=3 -> result=0x0002.
REQ-032 MUL a=255, b=255 -> result=0xFE01, done exactly 9 cycles after E0, busy high throughout; a/b toggled during MUL do not change the result.
REQ-033 SHL a=0x81, b=0x0B -> result=0x0408 (shift of 3); op=111 -> result=0, err=1; a following XOR 0xF0^0x3C -> 0x00CC with err=0.
REQ-034 Start MUL, assert rst at cycle 4 -> busy=0, done never pulses, result=0; the next ADD 1+1 -> 0x0002.
REQ-035 start held high continuously with ADD -> one done pulse every 2 cycles, and start is never accepted while in DONE.
